// File: rtl/core_fetcher.sv
// core_fetcher: per-core instruction fetcher.
// Waits for the controller to enter FETCH, issues a single read to program
// memory at the sampled PC, captures the returned instruction and reports
// FETCHED until the controller moves on to DECODE.
// Optional build macro FETCHER_PC_CACHE_EN adds a one-entry PC/instruction
// cache that short-circuits a refetch of the most recently fetched PC.
module core_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } fetch_state_t;

    fetch_state_t                     state_reg, state_next;
    logic                             valid_reg, valid_next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_reg, addr_next;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_reg, instr_next;

`ifdef FETCHER_PC_CACHE_EN
    logic [PROGRAM_MEM_ADDR_BITS-1:0] cache_tag_reg, cache_tag_next;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data_reg, cache_data_next;
    logic                             cache_vld_reg, cache_vld_next;
    logic                             cache_hit;

    // A hit needs a valid entry whose tag matches the PC being requested.
    assign cache_hit = cache_vld_reg && (cache_tag_reg == current_pc);

    // Cache entry register; invalidated by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_tag_reg  <= '0;
            cache_data_reg <= '0;
            cache_vld_reg  <= 1'b0;
        end else begin
            cache_tag_reg  <= cache_tag_next;
            cache_data_reg <= cache_data_next;
            cache_vld_reg  <= cache_vld_next;
        end
    end
`endif

    // State and output registers; reset aborts any fetch in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            addr_reg  <= addr_next;
            instr_reg <= instr_next;
        end
    end

    // Next-state and next-output logic for the fetch handshake.
    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        addr_next  = addr_reg;
        instr_next = instr_reg;
`ifdef FETCHER_PC_CACHE_EN
        cache_tag_next  = cache_tag_reg;
        cache_data_next = cache_data_reg;
        cache_vld_next  = cache_vld_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (core_state == CORE_FETCH) begin
`ifdef FETCHER_PC_CACHE_EN
                    if (cache_hit) begin
                        state_next = FETCHED;
                        instr_next = cache_data_reg;
                    end else begin
                        state_next = FETCHING;
                        valid_next = 1'b1;
                        addr_next  = current_pc;
                    end
`else
                    state_next = FETCHING;
                    valid_next = 1'b1;
                    addr_next  = current_pc;
`endif
                end
            end
            FETCHING: begin
                // Address and valid stay frozen until memory answers.
                if (mem_read_ready) begin
                    state_next = FETCHED;
                    valid_next = 1'b0;
                    instr_next = mem_read_data;
`ifdef FETCHER_PC_CACHE_EN
                    cache_tag_next  = addr_reg;
                    cache_data_next = mem_read_data;
                    cache_vld_next  = 1'b1;
`endif
                end
            end
            FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    assign mem_read_valid   = valid_reg;
    assign mem_read_address = addr_reg;
    assign fetcher_state    = state_reg;
    assign instruction      = instr_reg;

endmodule

// File: tb/tb_core_fetcher.sv
// Directed self-checking bench for core_fetcher (default and cached builds).
module tb_core_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] C_IDLE = 3'b000, C_FETCH = 3'b001, C_DECODE = 3'b010;
    localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;

    core_fetcher dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    always #5 clk = ~clk;

    // Program memory contents used by the sweep: distinct per address.
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full memory fetch: request, wait cycles, response, then DECODE back to IDLE.
    task automatic mem_fetch(input logic [7:0] pc, input logic [15:0] data, input int waits);
        core_state = C_FETCH;
        current_pc = pc;
        tick();
        chk("req_valid", 32'(mem_read_valid), 32'd1);
        chk("req_addr", 32'(mem_read_address), 32'(pc));
        chk("req_state", 32'(fetcher_state), 32'(S_FETCHING));
        current_pc = pc + 8'd1;
        for (int w = 0; w < waits; w++) begin
            tick();
            chk("wait_addr", 32'(mem_read_address), 32'(pc));
        end
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick();
        mem_read_ready = 1'b0;
        chk("cap_instr", 32'(instruction), 32'(data));
        chk("cap_state", 32'(fetcher_state), 32'(S_FETCHED));
        chk("cap_valid", 32'(mem_read_valid), 32'd0);
        core_state = C_DECODE;
        tick();
        chk("dec_state", 32'(fetcher_state), 32'(S_IDLE));
        $display("fetch pc=%02h data=%04h waits=%0d instr=%04h", pc, data, waits, instruction);
    endtask

    initial begin
        reset = 1'b1;
        core_state = C_IDLE;
        current_pc = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data = 16'h0000;
        tick();
        tick();
        chk("rst_state", 32'(fetcher_state), 32'(S_IDLE));
        chk("rst_valid", 32'(mem_read_valid), 32'd0);
        chk("rst_addr", 32'(mem_read_address), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        reset = 1'b0;

        // Idle with no FETCH request: never asks memory.
        tick();
        chk("idle_valid", 32'(mem_read_valid), 32'd0);

        // Tests 1/2: request at 0x05, 3 wait cycles, PC changes ignored.
        core_state = C_FETCH;
        current_pc = 8'h05;
        tick();
        chk("t1_valid", 32'(mem_read_valid), 32'd1);
        chk("t1_addr", 32'(mem_read_address), 32'h05);
        chk("t1_state", 32'(fetcher_state), 32'(S_FETCHING));
        current_pc = 8'h22;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("t2_wait_valid", 32'(mem_read_valid), 32'd1);
            chk("t2_wait_addr", 32'(mem_read_address), 32'h05);
            chk("t2_wait_state", 32'(fetcher_state), 32'(S_FETCHING));
        end
        mem_read_ready = 1'b1;
        mem_read_data = 16'hA1B2;
        tick();
        mem_read_ready = 1'b0;
        chk("t2_instr", 32'(instruction), 32'hA1B2);
        chk("t2_valid", 32'(mem_read_valid), 32'd0);
        chk("t2_state", 32'(fetcher_state), 32'(S_FETCHED));
        tick();
        chk("t2_hold_state", 32'(fetcher_state), 32'(S_FETCHED));
        $display("t1/t2 fetch pc=05 instr=%04h", instruction);

        // Test 3: DECODE returns to IDLE; spurious ready there is ignored.
        core_state = C_DECODE;
        tick();
        chk("t3_state", 32'(fetcher_state), 32'(S_IDLE));
        mem_read_ready = 1'b1;
        mem_read_data = 16'hFFFF;
        tick();
        mem_read_ready = 1'b0;
        chk("t3_spur_state", 32'(fetcher_state), 32'(S_IDLE));
        chk("t3_spur_instr", 32'(instruction), 32'hA1B2);
        chk("t3_spur_valid", 32'(mem_read_valid), 32'd0);
        $display("t3 decode/spurious ready state=%0d instr=%04h", fetcher_state, instruction);

        // Test 4: reset while FETCHING, late ready ignored.
        core_state = C_FETCH;
        current_pc = 8'h33;
        tick();
        chk("t4_fetching", 32'(fetcher_state), 32'(S_FETCHING));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        core_state = C_IDLE;
        chk("t4_state", 32'(fetcher_state), 32'(S_IDLE));
        chk("t4_valid", 32'(mem_read_valid), 32'd0);
        chk("t4_instr", 32'(instruction), 32'd0);
        mem_read_ready = 1'b1;
        mem_read_data = 16'hBEEF;
        tick();
        mem_read_ready = 1'b0;
        chk("t4_late_state", 32'(fetcher_state), 32'(S_IDLE));
        chk("t4_late_instr", 32'(instruction), 32'd0);
        $display("t4 reset mid-fetch state=%0d instr=%04h", fetcher_state, instruction);

        // Test 5: refetch of the same PC (cache hit only in the cached build).
        mem_fetch(8'h10, 16'h1234, 1);
        core_state = C_FETCH;
        current_pc = 8'h10;
        tick();
`ifdef FETCHER_PC_CACHE_EN
        chk("t5_hit_valid", 32'(mem_read_valid), 32'd0);
        chk("t5_hit_state", 32'(fetcher_state), 32'(S_FETCHED));
        chk("t5_hit_instr", 32'(instruction), 32'h1234);
        core_state = C_DECODE;
        tick();
        chk("t5_hit_dec", 32'(fetcher_state), 32'(S_IDLE));
        $display("t5 cache hit pc=10 instr=%04h", instruction);
        mem_fetch(8'h11, 16'h5678, 0);
`else
        chk("t5_refetch_valid", 32'(mem_read_valid), 32'd1);
        chk("t5_refetch_state", 32'(fetcher_state), 32'(S_FETCHING));
        mem_read_ready = 1'b1;
        mem_read_data = 16'h4321;
        tick();
        mem_read_ready = 1'b0;
        chk("t5_refetch_instr", 32'(instruction), 32'h4321);
        core_state = C_DECODE;
        tick();
        $display("t5 refetch pc=10 from memory instr=%04h", instruction);
`endif

        // Test 6: sweep every PC plus one wrap back to 0.
        for (int i = 0; i < 257; i++) begin
            mem_fetch(8'(i), mem_word(8'(i)), i % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
